neuron_mac: RTL

- Serial multiply-accumulate neuron core: consumes NIN (input, weight) pairs over a valid/ready stream, adds a bias, rescales and saturates to the data format, then presents one PREC-bit weighted sum.
- Sits directly upstream of the step activation stage; out_sum drives the activation's `in`, and both use the same dconf_t CONF.

---
 rtl/neuron_mac_pkg.sv | 41 ++++
 rtl/fxp_rescale_sat.sv | 59 +++++
 rtl/neuron_mac.sv | 129 ++++++++++++
 3 files changed

// File: rtl/neuron_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module  : neuron_mac_pkg
// Brief   : Data-format configuration, MAC state encoding and width helpers
// Revision: 1.0 - initial release
// ============================================================================
package neuron_mac_pkg;

    typedef enum logic [1:0] {
        DT_BOOL = 2'd0,
        DT_INT  = 2'd1,
        DT_FXP  = 2'd2,
        DT_FP   = 2'd3
    } dtype_t;

    typedef struct packed {
        dtype_t     dtype;
        logic       sign;
        logic [7:0] frac;
        logic [7:0] prec;
    } dconf_t;

    localparam dconf_t DEF_DCONF_FXP = '{dtype: DT_FXP, sign: 1'b1, frac: 8'd4, prec: 8'd8};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } mac_state_t;

    function automatic int acc_width(input int prec, input int nin);
        return 2 * prec + $clog2(nin + 1);
    endfunction

    // Integer formats carry no fraction regardless of the frac field
    function automatic int frac_bits(input dconf_t conf);
        return (conf.dtype == DT_FXP) ? int'(conf.frac) : 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fxp_rescale_sat.sv
`default_nettype none
// ============================================================================
// Module  : fxp_rescale_sat
// Brief   : Drops FRAC fraction bits from a double-precision accumulator and
//           clamps the result to the CONF data range
// Revision: 1.0 - initial release
// ============================================================================
module fxp_rescale_sat
    import neuron_mac_pkg::*;
#(
    parameter dconf_t CONF = DEF_DCONF_FXP,
    parameter int     ACCW = 19
) (
    input  logic [ACCW-1:0]      acc,
    output logic [CONF.prec-1:0] sum,
    output logic                 sat
);

    localparam int c_prec = int'(CONF.prec);
    localparam int c_frac = frac_bits(CONF);

    generate
        if (CONF.sign) begin : g_signed
            localparam logic signed [ACCW-1:0] c_max = {{(ACCW-c_prec+1){1'b0}}, {(c_prec-1){1'b1}}};
            localparam logic signed [ACCW-1:0] c_min = {{(ACCW-c_prec+1){1'b1}}, {(c_prec-1){1'b0}}};
            logic signed [ACCW-1:0] w_shift;

            // Arithmetic shift floors toward -infinity
            assign w_shift = $signed(acc) >>> c_frac;

            always_comb begin
                sum = w_shift[c_prec-1:0];
                sat = 1'b0;
                if (w_shift > c_max) begin
                    sum = c_max[c_prec-1:0];
                    sat = 1'b1;
                end else if (w_shift < c_min) begin
                    sum = c_min[c_prec-1:0];
                    sat = 1'b1;
                end
            end
        end else begin : g_unsigned
            logic [ACCW-1:0] w_shift;

            assign w_shift = acc >> c_frac;

            always_comb begin
                sum = w_shift[c_prec-1:0];
                sat = 1'b0;
                if (w_shift[ACCW-1:c_prec] != '0) begin
                    sum = '1;
                    sat = 1'b1;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
// Module  : neuron_mac
// Brief   : Serial multiply-accumulate neuron: NIN (x, w) beats plus bias,
//           rescaled and saturated to one CONF-format weighted sum
// Revision: 1.0 - initial release
// ============================================================================
module neuron_mac
    import neuron_mac_pkg::*;
#(
    parameter dconf_t CONF = DEF_DCONF_FXP,
    parameter int     PREC = int'(CONF.prec),
    parameter int     NIN  = 4
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic [PREC-1:0] bias,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PREC-1:0] in_x,
    input  logic [PREC-1:0] in_w,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PREC-1:0] out_sum,
    output logic            out_sat
);

    localparam int ACCW     = acc_width(PREC, NIN);
    localparam int c_frac   = frac_bits(CONF);
    localparam int c_cntw   = $clog2(NIN + 1);
    localparam bit c_supported = (CONF.dtype == DT_INT) || (CONF.dtype == DT_FXP);
    localparam logic [c_cntw-1:0] c_last = c_cntw'(NIN - 1);

    mac_state_t        r_state;
    logic [c_cntw-1:0] r_cnt;
    logic [ACCW-1:0]   r_acc;
    logic              r_out_valid;
    logic [PREC-1:0]   r_sum;
    logic              r_sat;

    logic [ACCW-1:0]   w_prod;
    logic [ACCW-1:0]   w_bias;
    logic [ACCW-1:0]   w_acc_next;
    logic [PREC-1:0]   w_sum;
    logic              w_sat;
    logic              w_accept;

    generate
        if (CONF.sign) begin : g_sext
            logic signed [2*PREC-1:0] w_prod_s;
            assign w_prod_s = $signed(in_x) * $signed(in_w);
            assign w_prod   = {{(ACCW-2*PREC){w_prod_s[2*PREC-1]}}, w_prod_s};
            assign w_bias   = {{(ACCW-PREC){bias[PREC-1]}}, bias} << c_frac;
        end else begin : g_zext
            logic [2*PREC-1:0] w_prod_u;
            assign w_prod_u = in_x * in_w;
            assign w_prod   = {{(ACCW-2*PREC){1'b0}}, w_prod_u};
            assign w_bias   = {{(ACCW-PREC){1'b0}}, bias} << c_frac;
        end
    endgenerate

    assign in_ready   = !c_supported || (r_state != OUT);
    assign w_accept   = in_valid && in_ready;
    // The first beat seeds the accumulator with the bias aligned to 2*FRAC
    assign w_acc_next = ((r_state == IDLE) ? w_bias : r_acc) + w_prod;

    fxp_rescale_sat #(
        .CONF (CONF),
        .ACCW (ACCW)
    ) u_rescale (
        .acc (w_acc_next),
        .sum (w_sum),
        .sat (w_sat)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_sat       <= 1'b0;
        end else if (c_supported) begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        r_cnt <= c_cntw'(1);
                        if (NIN == 1) begin
                            r_state     <= OUT;
                            r_out_valid <= 1'b1;
                            r_sum       <= w_sum;
                            r_sat       <= w_sat;
                        end else begin
                            r_state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_last) begin
                            r_state     <= OUT;
                            r_out_valid <= 1'b1;
                            r_sum       <= w_sum;
                            r_sat       <= w_sat;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_sum;
    assign out_sat   = r_sat;

endmodule
`default_nettype wire
